// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: address width, instruction size and reset vector.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/pc_adder.sv
// Constant-increment adder. The carry out is dropped, so the sum wraps modulo 2^WIDTH.
module pc_adder #(
    parameter int WIDTH = 32,
    parameter int INCR  = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = a + WIDTH'(INCR);

endmodule

// File: rtl/pc_plus4.sv
// Fetch-stage PC source: a combinational next-sequential address for pc_actual, plus a
// registered PC that supports stall and redirect.
module pc_plus4
    import riscv_pkg::*;
#(
    parameter int               XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(riscv_pkg::RESET_VECTOR),
    parameter int               INCR         = riscv_pkg::INSTR_BYTES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_actual,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_misaligned,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_q_plus4
);

    pc_adder #(
        .WIDTH (XLEN),
        .INCR  (INCR)
    ) u_next_adder (
        .a (pc_actual),
        .y (pc_next)
    );

    pc_adder #(
        .WIDTH (XLEN),
        .INCR  (INCR)
    ) u_q_adder (
        .a (pc_q),
        .y (pc_q_plus4)
    );

    assign pc_misaligned = |pc_actual[1:0];

    // A redirect must win over a stall so that a taken branch is never lost while fetch is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (redirect_valid) begin
            pc_q <= redirect_target;
        end else if (!stall) begin
            pc_q <= pc_q_plus4;
        end
    end

endmodule

// File: tb/tb_pc_plus4.sv
// Directed bench for pc_plus4: combinational increment and wrap, async reset, stall, redirect priority.
module tb_pc_plus4;
    import riscv_pkg::*;

    logic  clk;
    logic  clk_en;
    logic  rst_n;
    addr_t pc_actual;
    addr_t pc_next;
    logic  pc_misaligned;
    logic  stall;
    logic  redirect_valid;
    addr_t redirect_target;
    addr_t pc_q;
    addr_t pc_q_plus4;

    int test_count;
    int fail_count;

    pc_plus4 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_actual       (pc_actual),
        .pc_next         (pc_next),
        .pc_misaligned   (pc_misaligned),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_q            (pc_q),
        .pc_q_plus4      (pc_q_plus4)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input addr_t pc, input logic stl, input logic rv, input addr_t tgt);
        pc_actual       = pc;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = tgt;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPc(input string tag, input logic [31:0] exp_q);
        checkOutput({tag, "_pc_q"}, pc_q, exp_q);
        checkOutput({tag, "_pc_q_plus4"}, pc_q_plus4, exp_q + 32'd4);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        test_count = 0;
        fail_count = 0;
        clk_en     = 1'b0;
        rst_n      = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);

        #100;
        checkOutput("reset_pc_q", pc_q, 32'h0);
        checkOutput("next_0", pc_next, 32'h4);
        checkOutput("misal_0", {31'b0, pc_misaligned}, 32'h0);

        applyStimulus(32'h1, 1'b0, 1'b0, 32'h0);
        #100;
        checkOutput("next_1", pc_next, 32'h5);
        checkOutput("misal_1", {31'b0, pc_misaligned}, 32'h1);

        applyStimulus(32'h4, 1'b0, 1'b0, 32'h0);
        #100;
        checkOutput("next_4", pc_next, 32'h8);
        checkOutput("misal_4", {31'b0, pc_misaligned}, 32'h0);

        applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        #100;
        checkOutput("wrap_fffffffc", pc_next, 32'h0);

        applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        #100;
        checkOutput("wrap_ffffffff", pc_next, 32'h3);
        checkOutput("misal_ffffffff", {31'b0, pc_misaligned}, 32'h1);

        // Free-run from reset: 4, 8, 12.
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            stepClock();
            checkPc($sformatf("run%0d", i), 32'(4 * i));
        end

        // Async reset mid-cycle, away from any edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", pc_q, 32'h0);
        stepClock();
        checkOutput("reset_held", pc_q, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        stepClock();
        checkPc("pre_stall1", 32'h4);
        stepClock();
        checkPc("pre_stall2", 32'h8);

        @(negedge clk);
        applyStimulus(32'h10, 1'b1, 1'b0, 32'h0);
        stepClock();
        checkPc("stall1", 32'h8);
        stepClock();
        checkPc("stall2", 32'h8);
        @(negedge clk);
        applyStimulus(32'h10, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkPc("unstall", 32'hC);

        @(negedge clk);
        applyStimulus(32'h10, 1'b1, 1'b1, 32'h0000_0100);
        stepClock();
        checkPc("redirect_over_stall", 32'h100);
        @(negedge clk);
        applyStimulus(32'h10, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkPc("after_redirect", 32'h104);

        // Reset while a redirect is pending; the adder path must keep working.
        @(negedge clk);
        applyStimulus(32'h0000_1000, 1'b0, 1'b1, 32'h0000_0200);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_during_redirect", pc_q, 32'h0);
        checkOutput("next_in_reset", pc_next, 32'h0000_1004);
        stepClock();
        checkOutput("reset_beats_redirect", pc_q, 32'h0);
        applyStimulus(32'h0000_2002, 1'b0, 1'b1, 32'h0000_0200);
        #1;
        checkOutput("next_in_reset2", pc_next, 32'h0000_2006);
        @(negedge clk);
        rst_n = 1'b1;
        stepClock();
        checkPc("redirect_after_release", 32'h200);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
